mem_bist_master: RTL and testbench
==================================

Name: mem_bist_master

Overview:
- Bus initiator on the high-level memory interface (mem_addr / r_en / w_en / rdy / cplt / data); drives the memory controller from the requester side.
- Runs a write-then-readback memory test over an address window and checks each readback word.
- Skips the memory-mapped I/O address; at the end it writes the error count to that address so the seven-segment display shows it.
- Sits at top level in place of, or muxed with, the CPU master.

Parameters:
- ADDR_WIDTH, 16, address width.
- DATA_WIDTH, 16, data width.
- START_ADDR, 16'h0000, first test address (inclusive).
- END_ADDR, 16'h00FF, last test address (inclusive); must be >= START_ADDR.
- IO_ADDR, 16'h0100, I/O address: excluded from the test and used as the report target.
- SEED, 16'h5A5A, pattern seed.
- TIMEOUT, 1024, maximum cycles to wait for mem_cplt.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begins a test when sampled high in IDLE or DONE.
- mem_addr  out  ADDR_WIDTH  request address.
- mem_wdata  out  DATA_WIDTH  write data to the controller.
- mem_r_en  out  1  read request strobe.
- mem_w_en  out  1  write request strobe.
- mem_rdy  in  1  controller can accept a request.
- mem_cplt  in  1  one-cycle completion pulse.
- mem_rdata  in  DATA_WIDTH  read data; valid when mem_cplt=1.
- busy  out  1  test in progress.
- done  out  1  test finished; held until the next start.
- pass  out  1  valid when done=1; 1 means zero errors.
- err_count  out  16  count of mismatches plus timeouts; saturates at 16'hFFFF.
- first_err_addr  out  ADDR_WIDTH  address of the first error; 0 if there was none.

Behaviour:
- Reset values: mem_addr=0, mem_wdata=0, mem_r_en=0, mem_w_en=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, state=IDLE. All outputs are registered.
- Reset mid-transaction returns immediately to IDLE with strobes low. Any outstanding mem_cplt after reset is ignored, because it arrives in IDLE.
- Pattern: pat(a) = a[15:0] XOR SEED. Width rule: the address is zero-extended or truncated to DATA_WIDTH.
- Request rule:
  - A strobe is asserted for exactly one cycle, and only in a cycle where mem_rdy=1 is sampled.
  - mem_addr and mem_wdata are stable in that cycle and held until mem_cplt.
  - Never both strobes at once. Never a new strobe before the prior mem_cplt or timeout.
- Completion rule:
  - Wait for mem_cplt=1, which can come 1 or more cycles after the strobe.
  - On a read, capture mem_rdata in the mem_cplt cycle.
  - mem_cplt in the same cycle as the strobe is not a completion of that request; ignore it.
- Timeout: a wait counter resets at each strobe. If it reaches TIMEOUT without mem_cplt:
  - err_count increments (saturating);
  - first_err_addr is recorded if this is the first error;
  - the FSM proceeds as if completed.
- FSM states and transitions:
  - IDLE: start -> WR_REQ; addr=START_ADDR; err_count, first_err_addr, done and pass cleared; busy=1.
  - WR_REQ: when mem_rdy=1, pulse mem_w_en with pat(addr) -> WR_WAIT.
  - WR_WAIT: cplt or timeout. If addr==END_ADDR -> RD_REQ with addr=START_ADDR; else advance addr -> WR_REQ.
  - RD_REQ: when mem_rdy=1, pulse mem_r_en -> RD_WAIT.
  - RD_WAIT: on cplt, compare mem_rdata with pat(addr). On mismatch: err_count++ and record first_err_addr if this is the first error. If addr==END_ADDR -> RPT_REQ; else advance -> RD_REQ.
  - RPT_REQ: when mem_rdy=1, pulse mem_w_en with addr=IO_ADDR and wdata=err_count -> RPT_WAIT.
  - RPT_WAIT: cplt or timeout -> DONE. A timeout here does not increment err_count.
  - DONE: busy=0, done=1, pass=(err_count==0). start -> same actions as from IDLE.
- Address advance: addr+1, and a second +1 if the result equals IO_ADDR. If IO_ADDR==END_ADDR, then END_ADDR-1 is treated as the last address.
- Degenerate window: if START_ADDR==IO_ADDR, the walk starts at START_ADDR+1. If the window contains only IO_ADDR, go straight to RPT_REQ.
- start while busy=1 is ignored.
- mem_rdy low in a REQ state: hold the state, strobes stay low.

Decomposition:
- Package mem_bist_pkg: state enum (IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, RPT_REQ, RPT_WAIT, DONE), default IO_ADDR constant, pattern function pat().
- Sub-module mem_req_timer: wait counter with restart and expired outputs, parameterised by TIMEOUT.

Test Plan:
- Ideal model (mem_rdy=1, cplt 3 cycles after strobe, correct data), START=0x00F0, END=0x00FF, start pulse -> 16 writes with wdata=addr^0x5A5A, 16 reads, report write of 0x0000 to 0x0100; done=1, pass=1.
- Window START=0x00FE, END=0x0102 -> addresses 0xFE, 0xFF, 0x101, 0x102 only; no strobe to 0x100 except the final report write.
- Model corrupts the read at 0x00F3 (returns 0x0000) -> err_count=1, first_err_addr=0x00F3, pass=0, report wdata=0x0001.
- Model holds mem_rdy=0 for 20 cycles before each request -> no strobe while mem_rdy=0, each strobe exactly 1 cycle, result identical to the ideal case.
- Model drops the cplt for the write at 0x00F5, TIMEOUT=16 -> FSM resumes 16 cycles after that strobe; err_count>=1; first_err_addr=0x00F5.
- rst asserted during RD_WAIT -> outputs return to reset values asynchronously; the late cplt is ignored; a new start reruns the test cleanly with err_count starting from 0.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory BIST bus master: FSM state encoding,
// default I/O report address and the address-derived test pattern.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT,
    RPT_REQ,
    RPT_WAIT,
    DONE
  } state_t;

  localparam logic [15:0] DEF_IO_ADDR = 16'h0100;
  localparam logic [15:0] DEF_SEED    = 16'h5A5A;

  // Test word for an address: the low 16 address bits XOR the seed.
  function automatic logic [15:0] pat(input logic [15:0] addr, input logic [15:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/mem_bist_master_if.sv
// High-level memory request interface between a requester (master) and the
// memory controller (slave): one-cycle strobes, rdy gating, one-cycle cplt.
interface mem_bist_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_r_en;
  logic                  mem_w_en;
  logic                  mem_rdy;
  logic                  mem_cplt;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_r_en, mem_w_en,
    input  mem_rdy, mem_cplt, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_r_en, mem_w_en,
    output mem_rdy, mem_cplt, mem_rdata
  );
endinterface

// File: rtl/mem_req_timer.sv
// Completion wait counter: cleared on restart, saturates one short of TIMEOUT
// so that expired is seen in the TIMEOUT-th cycle after the strobe.
module mem_req_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic expired
);

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // NOTE: state is updated with non-blocking assignments and reset
  // asynchronously, so every register sees pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (restart)          cnt <= '0;
    else if (cnt != LAST_CNT)  cnt <= cnt + CW'(1);
  end

  assign expired = (cnt == LAST_CNT);

endmodule

// File: rtl/mem_bist_master.sv
// Write-then-readback memory test master: walks an address window skipping the
// I/O address, verifies each word, then writes the error count to the I/O address.
module mem_bist_master
  import mem_bist_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 16,
  parameter logic [15:0] START_ADDR = 16'h0000,
  parameter logic [15:0] END_ADDR   = 16'h00FF,
  parameter logic [15:0] IO_ADDR    = DEF_IO_ADDR,
  parameter logic [15:0] SEED       = DEF_SEED,
  parameter int          TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  mem_bist_master_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t START_A = addr_t'(START_ADDR);
  localparam addr_t END_A   = addr_t'(END_ADDR);
  localparam addr_t IO_A    = addr_t'(IO_ADDR);
  localparam addr_t FIRST_A = (START_A == IO_A) ? START_A + addr_t'(1) : START_A;
  localparam addr_t LAST_A  = (END_A == IO_A) ? END_A - addr_t'(1) : END_A;
  localparam bit    EMPTY   = (START_A == IO_A) && (END_A == IO_A);

  function automatic logic [DATA_WIDTH-1:0] pat_word(input addr_t a);
    return DATA_WIDTH'(pat(16'(a), SEED));
  endfunction

  function automatic addr_t next_addr(input addr_t a);
    addr_t n;
    n = a + addr_t'(1);
    if (n == IO_A) n = n + addr_t'(1);
    return n;
  endfunction

  state_t      state;
  addr_t       cur_addr;
  logic        restart;
  logic        expired;
  logic        cplt_ok;
  logic        rd_bad;
  logic [15:0] err_inc;

  // A cplt seen while our own strobe is still high belongs to an earlier request.
  assign cplt_ok = bus.mem_cplt && !bus.mem_w_en && !bus.mem_r_en;
  assign rd_bad  = cplt_ok ? (bus.mem_rdata != pat_word(cur_addr)) : 1'b1;
  assign err_inc = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
  assign restart = bus.mem_rdy && (state == WR_REQ || state == RD_REQ || state == RPT_REQ);

  mem_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cur_addr       <= '0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.mem_r_en   <= 1'b0;
      bus.mem_w_en   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      // NOTE: strobes default low each cycle, which makes every strobe exactly one cycle wide.
      bus.mem_w_en <= 1'b0;
      bus.mem_r_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cur_addr       <= FIRST_A;
            err_count      <= '0;
            first_err_addr <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            state          <= EMPTY ? RPT_REQ : WR_REQ;
          end
        end
        WR_REQ: begin
          if (bus.mem_rdy) begin
            bus.mem_w_en  <= 1'b1;
            bus.mem_addr  <= cur_addr;
            bus.mem_wdata <= pat_word(cur_addr);
            state         <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (cplt_ok || expired) begin
            if (!cplt_ok) begin
              err_count <= err_inc;
              if (err_count == 16'd0) first_err_addr <= cur_addr;
            end
            if (cur_addr == LAST_A) begin
              cur_addr <= FIRST_A;
              state    <= RD_REQ;
            end else begin
              cur_addr <= next_addr(cur_addr);
              state    <= WR_REQ;
            end
          end
        end
        RD_REQ: begin
          if (bus.mem_rdy) begin
            bus.mem_r_en <= 1'b1;
            bus.mem_addr <= cur_addr;
            state        <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cplt_ok || expired) begin
            if (rd_bad) begin
              err_count <= err_inc;
              if (err_count == 16'd0) first_err_addr <= cur_addr;
            end
            if (cur_addr == LAST_A) begin
              state <= RPT_REQ;
            end else begin
              cur_addr <= next_addr(cur_addr);
              state    <= RD_REQ;
            end
          end
        end
        RPT_REQ: begin
          if (bus.mem_rdy) begin
            bus.mem_w_en  <= 1'b1;
            bus.mem_addr  <= IO_A;
            bus.mem_wdata <= DATA_WIDTH'(err_count);
            state         <= RPT_WAIT;
          end
        end
        RPT_WAIT: begin
          // A lost report completion is not counted: the result is already final.
          if (cplt_ok || expired) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 16'd0);
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_master.sv
// Self-checking bench: a memory model answers requests from one of two BIST
// masters and a scoreboard checks the ordered request stream and final status.
module tb_mem_bist_master;

  localparam int          TO   = 16;
  localparam int          LAT  = 3;
  localparam logic [15:0] IO   = 16'h0100;
  localparam logic [15:0] SD   = 16'h5A5A;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  always #5 clk = ~clk;

  mem_bist_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus_a ();
  mem_bist_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus_b ();

  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [15:0] err_a, first_a, err_b, first_b;

  mem_bist_master #(.START_ADDR(16'h00F0), .END_ADDR(16'h00FF), .TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bus(bus_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_addr(first_a)
  );

  mem_bist_master #(.START_ADDR(16'h00FE), .END_ADDR(16'h0102), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bus(bus_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_err_addr(first_b)
  );

  // Model drives both controllers' inputs; sel picks whose requests it serves.
  bit          sel = 1'b0;
  logic        rdy = 1'b1, cplt = 1'b0;
  logic [15:0] rdata = '0;
  logic [15:0] m_addr, m_wdata;
  logic        m_w, m_r;
  logic        s_busy, s_done, s_pass;
  logic [15:0] s_err, s_first;

  assign bus_a.mem_rdy = rdy;  assign bus_a.mem_cplt = cplt;  assign bus_a.mem_rdata = rdata;
  assign bus_b.mem_rdy = rdy;  assign bus_b.mem_cplt = cplt;  assign bus_b.mem_rdata = rdata;
  assign m_addr  = sel ? bus_b.mem_addr  : bus_a.mem_addr;
  assign m_wdata = sel ? bus_b.mem_wdata : bus_a.mem_wdata;
  assign m_w     = sel ? bus_b.mem_w_en  : bus_a.mem_w_en;
  assign m_r     = sel ? bus_b.mem_r_en  : bus_a.mem_r_en;
  assign s_busy  = sel ? busy_b  : busy_a;
  assign s_done  = sel ? done_b  : done_a;
  assign s_pass  = sel ? pass_b  : pass_a;
  assign s_err   = sel ? err_b   : err_a;
  assign s_first = sel ? first_b : first_a;

  req_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  int          rdy_gap = 0;
  int          gap_cnt = 0;
  logic        corrupt_en = 1'b0, drop_en = 1'b0;
  logic [15:0] corrupt_addr = '0, drop_addr = '0;
  logic [15:0] mem_model [logic [15:0]];
  int          cyc = 0;
  int          drop_cyc = 0, drop_gap = 0;
  bit          drop_wait = 1'b0, gap_valid = 1'b0;

  initial begin : model
    int          lat_cnt;
    bit          outstanding, prev_strobe, strobe, ok;
    logic [15:0] pend;
    req_t        exp;
    lat_cnt = 0; outstanding = 1'b0; prev_strobe = 1'b0; pend = '0;
    forever begin
      @(negedge clk);
      cyc++;
      cplt = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          cplt = 1'b1; rdata = pend; outstanding = 1'b0;
        end
      end
      strobe = m_w | m_r;
      if (strobe) begin
        ok = !(m_w && m_r) && !prev_strobe && rdy && !outstanding;
        checks++;
        if (!ok)
          $display("FAIL protocol @%0t: w=%b r=%b prev=%b rdy=%b outstanding=%b, required w^r, rdy=1, idle bus",
                   $time, m_w, m_r, prev_strobe, rdy, outstanding);
        if (!ok) errors++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL seq_extra: strobe w=%b addr=%h, required no request", m_w, m_addr);
        end else begin
          exp = sb_q.pop_front();
          if (exp.wr !== m_w || exp.addr !== m_addr || (exp.wr && exp.data !== m_wdata)) begin
            errors++;
            $display("FAIL seq_req: got w=%b addr=%h wdata=%h, required w=%b addr=%h wdata=%h",
                     m_w, m_addr, m_wdata, exp.wr, exp.addr, exp.data);
          end
        end
        if (drop_wait) begin
          drop_gap = cyc - drop_cyc; gap_valid = 1'b1; drop_wait = 1'b0;
        end
        if (m_w) mem_model[m_addr] = m_wdata;
        if (m_r) begin
          if (corrupt_en && m_addr == corrupt_addr) pend = 16'h0000;
          else if (mem_model.exists(m_addr))        pend = mem_model[m_addr];
          else                                      pend = 16'hDEAD;
        end
        if (drop_en && m_w && m_addr == drop_addr) begin
          drop_cyc = cyc; drop_wait = 1'b1; lat_cnt = 0; outstanding = 1'b0;
        end else begin
          lat_cnt = LAT; outstanding = 1'b1;
        end
        gap_cnt = rdy_gap;
      end
      prev_strobe = strobe;
      rdy = (gap_cnt == 0);
      if (gap_cnt > 0) gap_cnt--;
    end
  end

  task automatic push_expected(input bit s, input logic [15:0] exp_err);
    logic [15:0] lo, hi;
    lo = s ? 16'h00FE : 16'h00F0;
    hi = s ? 16'h0102 : 16'h00FF;
    for (int a = int'(lo); a <= int'(hi); a++)
      if (16'(a) != IO) sb_q.push_back('{1'b1, 16'(a), 16'(a) ^ SD});
    for (int a = int'(lo); a <= int'(hi); a++)
      if (16'(a) != IO) sb_q.push_back('{1'b0, 16'(a), 16'h0000});
    sb_q.push_back('{1'b1, IO, exp_err});
  endtask

  task automatic pulse_start(input bit s);
    @(posedge clk); #1;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic run_test(input bit s, input logic [15:0] exp_err, input logic [15:0] exp_first,
                          input bit poke, input string name);
    int n;
    sel = s;
    gap_cnt = rdy_gap;
    push_expected(s, exp_err);
    pulse_start(s);
    checks++;
    if (s_busy !== 1'b1) begin
      errors++; $display("FAIL %s_busy: got %b, required 1", name, s_busy);
    end
    if (poke) begin
      repeat (40) @(posedge clk);
      pulse_start(s);
    end
    n = 0;
    while (s_done !== 1'b1 && n < 5000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (s_done !== 1'b1) begin
      errors++; $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, s_done, n);
    end
    @(negedge clk);
    checks++;
    if (s_busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end: got %b, required 0", name, s_busy); end
    checks++;
    if (s_pass !== (exp_err == 16'd0)) begin
      errors++; $display("FAIL %s_pass: got %b, required %b", name, s_pass, exp_err == 16'd0);
    end
    checks++;
    if (s_err !== exp_err) begin errors++; $display("FAIL %s_err_count: got %h, required %h", name, s_err, exp_err); end
    checks++;
    if (s_first !== exp_first) begin
      errors++; $display("FAIL %s_first_err_addr: got %h, required %h", name, s_first, exp_first);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL %s_missing_requests: %0d left, required 0", name, sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_reset;
    logic [71:0] got_a, got_b;
    #1 rst = 1'b1;
    #1;
    got_a = {bus_a.mem_addr, bus_a.mem_wdata, bus_a.mem_r_en, bus_a.mem_w_en, busy_a, done_a, pass_a,
             err_a, first_a, 3'b000};
    got_b = {bus_b.mem_addr, bus_b.mem_wdata, bus_b.mem_r_en, bus_b.mem_w_en, busy_b, done_b, pass_b,
             err_b, first_b, 3'b000};
    checks++;
    if (got_a !== '0) begin errors++; $display("FAIL reset_a: got %h, required 0", got_a); end
    checks++;
    if (got_b !== '0) begin errors++; $display("FAIL reset_b: got %h, required 0", got_b); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ideal;
    run_test(1'b0, 16'h0000, 16'h0000, 1'b1, "ideal");
  endtask

  task automatic test_window;
    run_test(1'b1, 16'h0000, 16'h0000, 1'b0, "window");
  endtask

  task automatic test_corrupt;
    corrupt_en = 1'b1; corrupt_addr = 16'h00F3;
    run_test(1'b0, 16'h0001, 16'h00F3, 1'b0, "corrupt");
    corrupt_en = 1'b0;
  endtask

  task automatic test_rdy_gap;
    rdy_gap = 20;
    run_test(1'b0, 16'h0000, 16'h0000, 1'b0, "rdy_gap");
    rdy_gap = 0;
  endtask

  task automatic test_timeout;
    drop_en = 1'b1; drop_addr = 16'h00F5; gap_valid = 1'b0; drop_wait = 1'b0;
    run_test(1'b0, 16'h0001, 16'h00F5, 1'b0, "timeout");
    drop_en = 1'b0;
    checks++;
    if (!gap_valid || drop_gap < TO || drop_gap > TO + 2) begin
      errors++;
      $display("FAIL timeout_resume: valid=%b gap=%0d cycles, required %0d..%0d", gap_valid, drop_gap, TO, TO + 2);
    end
  endtask

  task automatic test_back_to_back;
    run_test(1'b0, 16'h0000, 16'h0000, 1'b0, "back_to_back");
  endtask

  task automatic test_reset_mid;
    int   n;
    bit   quiet;
    logic [71:0] got;
    sel = 1'b0;
    gap_cnt = 0;
    push_expected(1'b0, 16'h0000);
    pulse_start(1'b0);
    n = 0;
    while (!(bus_a.mem_r_en === 1'b1 && bus_a.mem_addr === 16'h00F4) && n < 5000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 5000) begin errors++; $display("FAIL rst_mid_wait: no read of 00f4 in %0d cycles, required one", n); end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    got = {bus_a.mem_addr, bus_a.mem_wdata, bus_a.mem_r_en, bus_a.mem_w_en, busy_a, done_a, pass_a,
           err_a, first_a, 3'b000};
    checks++;
    if (got !== '0) begin errors++; $display("FAIL rst_mid_async: got %h, required 0", got); end
    @(negedge clk); rst = 1'b0;
    sb_q.delete();
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus_a.mem_w_en !== 1'b0 || bus_a.mem_r_en !== 1'b0 || busy_a !== 1'b0 || err_a !== 16'd0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL rst_mid_late_cplt: activity after reset, required idle"); end
    run_test(1'b0, 16'h0000, 16'h0000, 1'b0, "rst_rerun");
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_window();
    test_corrupt();
    test_rdy_gap();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
